pla_sweep_compactor: RTL and testbench

Sequential driver and response compactor for a single-output PLA slice: a 16-input combinational block producing one bit. On command it sweeps a contiguous, possibly wrapping, range of 16-bit input vectors into the slice's x inputs, one vector per cycle. It samples the slice's output each cycle and compacts the responses into a ones count and a 16-bit MISR signature. It sits directly upstream (vector feed) and downstream (output capture) of the slice in the benchmark evaluation harness.

---
 rtl/pla_sweep_compactor.sv | 110 +++++++++++
 tb/tb_pla_sweep_compactor.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pla_sweep_compactor.sv
// pla_sweep_compactor
//   Drives a contiguous (possibly wrapping) range of 16-bit vectors into a
//   single-output PLA slice, one per cycle. It samples the slice output on the
//   same edge that retires each vector. The responses are compacted into a
//   ones count, a vector count and a 16-bit MISR signature.
//
// Ports
//   clk, rst       : clock, asynchronous active-high reset
//   start          : sweep request (accepted in IDLE only)
//   start_vec      : first vector, latched on accepted start
//   end_vec        : last vector (inclusive), latched on accepted start
//   abort          : end the sweep early (RUN only, current sample still kept)
//   pla_x          : vector driven to slice inputs x15..x0
//   pla_valid      : pla_x carries a live sweep vector
//   pla_y          : slice output y0, combinational in pla_x
//   busy           : sweep in progress
//   result_valid   : result fields valid, held until result_ready
//   result_ready   : consumer accepts result
//   ones_count     : sampled vectors with pla_y = 1
//   vec_count      : sampled vectors
//   signature      : MISR state
//   aborted        : result came from an aborted sweep
module pla_sweep_compactor #(
    parameter logic [15:0] POLY = 16'h1021,
    parameter logic [15:0] SEED = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] start_vec,
    input  logic [15:0] end_vec,
    input  logic        abort,
    output logic [15:0] pla_x,
    output logic        pla_valid,
    input  logic        pla_y,
    output logic        busy,
    output logic        result_valid,
    input  logic        result_ready,
    output logic [16:0] ones_count,
    output logic [16:0] vec_count,
    output logic [15:0] signature,
    output logic        aborted
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state;
    logic [15:0] end_q;
    logic [15:0] sig_next;

    // MISR step: shift left, fold in the polynomial on MSB carry-out, XOR the sample into bit 0
    always_comb begin
        sig_next = {signature[14:0], 1'b0} ^ (signature[15] ? POLY : '0) ^ {15'b0, pla_y};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            end_q      <= '0;
            pla_x      <= '0;
            ones_count <= '0;
            vec_count  <= '0;
            signature  <= SEED;
            aborted    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_RUN;
                        end_q      <= end_vec;
                        pla_x      <= start_vec;
                        ones_count <= '0;
                        vec_count  <= '0;
                        signature  <= SEED;
                        aborted    <= 1'b0;
                    end
                end
                S_RUN: begin
                    // The current vector is always compacted, even on the abort edge
                    ones_count <= ones_count + {16'b0, pla_y};
                    vec_count  <= vec_count + 17'd1;
                    signature  <= sig_next;
                    if (abort) begin
                        state   <= S_DONE;
                        aborted <= 1'b1;
                    end else if (pla_x == end_q) begin
                        state <= S_DONE;
                    end else begin
                        pla_x <= pla_x + 16'd1;
                    end
                end
                S_DONE: begin
                    if (result_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy         = (state == S_RUN);
        pla_valid    = (state == S_RUN);
        result_valid = (state == S_DONE);
    end

endmodule

// File: tb/tb_pla_sweep_compactor.sv
module tb_pla_sweep_compactor;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] start_vec;
    logic [15:0] end_vec;
    logic        abort;
    logic [15:0] pla_x;
    logic        pla_valid;
    logic        pla_y;
    logic        busy;
    logic        result_valid;
    logic        result_ready;
    logic [16:0] ones_count;
    logic [16:0] vec_count;
    logic [15:0] signature;
    logic        aborted;

    pla_sweep_compactor #(.POLY(16'h1021), .SEED(16'hFFFF)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .start_vec    (start_vec),
        .end_vec      (end_vec),
        .abort        (abort),
        .pla_x        (pla_x),
        .pla_valid    (pla_valid),
        .pla_y        (pla_y),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .ones_count   (ones_count),
        .vec_count    (vec_count),
        .signature    (signature),
        .aborted      (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [16:0] vec;
        logic [16:0] ones;
        logic [15:0] sig;
        logic        ab;
    } res_t;

    res_t        rq[$];
    logic [15:0] xq[$];
    bit          track_x;
    int          mode;
    int          tests;
    int          fails;

    // Slice stand-ins: 0 = tied high, 1 = x0, 2 = a real two-level function
    function automatic logic slice(input int m, input logic [15:0] x);
        if (m == 0) return 1'b1;
        if (m == 1) return x[0];
        return (^(x & 16'hB5C3)) ^ (x[3] & x[12]);
    endfunction

    function automatic logic [15:0] misr(input logic [15:0] s, input logic y);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'b0, y};
    endfunction

    always_comb pla_y = slice(mode, pla_x);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference sweep model; optionally queues the expected pla_x stream
    task automatic model(input logic [15:0] s, input logic [15:0] e, input int m,
                         input int ab_after, input bit push, output res_t r);
        logic [15:0] x;
        logic        y;
        r.vec  = '0;
        r.ones = '0;
        r.sig  = 16'hFFFF;
        r.ab   = (ab_after >= 0);
        x      = s;
        for (int k = 0; k < 65536; k++) begin
            y      = slice(m, x);
            r.ones = r.ones + {16'b0, y};
            r.vec  = r.vec + 17'd1;
            r.sig  = misr(r.sig, y);
            if (push) xq.push_back(x);
            if (k == ab_after || x == e) break;
            x = x + 16'd1;
        end
    endtask

    task automatic run_sweep(input logic [15:0] s, input logic [15:0] e, input int m,
                             input int ab_after, input bit hold, input bit poke, input res_t exp);
        mode = m;
        rq.push_back(exp);
        @(posedge clk); #1;
        start = 1'b1; start_vec = s; end_vec = e;
        @(posedge clk); #1;
        start = 1'b0; start_vec = 16'h0; end_vec = 16'h0;
        check("start_busy", {31'b0, busy}, 32'd1);
        check("start_vec_count", {15'b0, vec_count}, 32'd0);
        check("start_ones_count", {15'b0, ones_count}, 32'd0);
        check("start_signature", {16'b0, signature}, 32'h0000FFFF);
        if (poke) begin
            @(posedge clk); #1;
            start = 1'b1; start_vec = 16'h1234; end_vec = 16'h1234;
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (ab_after >= 0) begin
            repeat (ab_after) begin @(posedge clk); #1; end
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
        end
        for (int i = 0; i < 70000 && !result_valid; i++) @(negedge clk);
        check("result_timeout", {31'b0, result_valid}, 32'd1);
        if (hold) begin
            for (int i = 0; i < 5; i++) begin
                @(posedge clk); #1;
                start = (i == 2);
                check("hold_valid", {31'b0, result_valid}, 32'd1);
                check("hold_vec", {15'b0, vec_count}, {15'b0, exp.vec});
                check("hold_ones", {15'b0, ones_count}, {15'b0, exp.ones});
                check("hold_sig", {16'b0, signature}, {16'b0, exp.sig});
                check("hold_aborted", {31'b0, aborted}, {31'b0, exp.ab});
            end
            @(posedge clk); #1;
            start = 1'b0;
            check("done_start_ignored", {31'b0, busy}, 32'd0);
            // start together with ready only returns to IDLE
            start = 1'b1;
        end
        @(posedge clk); #1;
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        start = 1'b0;
        check("ready_drop_valid", {31'b0, result_valid}, 32'd0);
        @(posedge clk); #1;
        check("idle_after_ready", {31'b0, busy}, 32'd0);
        check("fields_keep_vec", {15'b0, vec_count}, {15'b0, exp.vec});
    endtask

    // Monitor: pla_x stream and result records are checked against the queues
    bit rv_prev;
    initial begin
        rv_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (pla_valid && track_x) begin
                if (xq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL pla_valid_extra: got pla_x %h expected no live vector", pla_x);
                end else begin
                    check("pla_x_seq", {16'b0, pla_x}, {16'b0, xq.pop_front()});
                end
            end
            if (result_valid && !rv_prev) begin
                if (rq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL result_unexpected: got result_valid 1 expected 0");
                end else begin
                    res_t r;
                    r = rq.pop_front();
                    check("res_vec_count", {15'b0, vec_count}, {15'b0, r.vec});
                    check("res_ones_count", {15'b0, ones_count}, {15'b0, r.ones});
                    check("res_signature", {16'b0, signature}, {16'b0, r.sig});
                    check("res_aborted", {31'b0, aborted}, {31'b0, r.ab});
                end
            end
            rv_prev = result_valid;
        end
    end

    initial begin
        res_t r;
        tests = 0; fails = 0;
        rst = 1'b1; start = 1'b0; start_vec = '0; end_vec = '0;
        abort = 1'b0; result_ready = 1'b0; mode = 0; track_x = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pla_x", {16'b0, pla_x}, 32'd0);
        check("rst_pla_valid", {31'b0, pla_valid}, 32'd0);
        check("rst_result_valid", {31'b0, result_valid}, 32'd0);
        check("rst_signature", {16'b0, signature}, 32'h0000FFFF);
        check("rst_vec_count", {15'b0, vec_count}, 32'd0);
        rst = 1'b0;

        // Single vector, y tied high: hand-computed MISR FFFF -> EFDE
        model(16'h0000, 16'h0000, 0, -1, 1'b1, r);
        r.vec = 17'd1; r.ones = 17'd1; r.sig = 16'hEFDE; r.ab = 1'b0;
        run_sweep(16'h0000, 16'h0000, 0, -1, 1'b0, 1'b0, r);

        // 0..9 with y = x0
        model(16'h0000, 16'h0009, 1, -1, 1'b1, r);
        r.vec = 17'd10; r.ones = 17'd5;
        run_sweep(16'h0000, 16'h0009, 1, -1, 1'b0, 1'b0, r);

        // Wrap FFFE..0001
        model(16'hFFFE, 16'h0001, 0, -1, 1'b1, r);
        r.vec = 17'd4; r.ones = 17'd4;
        run_sweep(16'hFFFE, 16'h0001, 0, -1, 1'b0, 1'b0, r);

        // Abort after 3 samples of 0..99; result held with start poked in DONE
        model(16'h0000, 16'h0063, 1, 3, 1'b1, r);
        r.vec = 17'd4; r.ones = 17'd2; r.ab = 1'b1;
        run_sweep(16'h0000, 16'h0063, 1, 3, 1'b1, 1'b0, r);

        // Start pulsed mid-RUN is ignored
        model(16'h0014, 16'h001D, 2, -1, 1'b1, r);
        run_sweep(16'h0014, 16'h001D, 2, -1, 1'b0, 1'b1, r);

        // Real slice over a wrapping range
        model(16'hFC00, 16'h0100, 2, -1, 1'b1, r);
        run_sweep(16'hFC00, 16'h0100, 2, -1, 1'b0, 1'b0, r);

        // Full sweep, y tied high
        track_x = 1'b0;
        model(16'h0000, 16'hFFFF, 0, -1, 1'b0, r);
        r.vec = 17'h10000; r.ones = 17'h10000;
        run_sweep(16'h0000, 16'hFFFF, 0, -1, 1'b0, 1'b0, r);

        // Reset mid-RUN takes effect without a clock edge
        mode = 1;
        @(posedge clk); #1;
        start = 1'b1; start_vec = 16'h0100; end_vec = 16'h0200;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        check("midrun_rst_busy", {31'b0, busy}, 32'd0);
        check("midrun_rst_pla_x", {16'b0, pla_x}, 32'd0);
        check("midrun_rst_vec", {15'b0, vec_count}, 32'd0);
        check("midrun_rst_sig", {16'b0, signature}, 32'h0000FFFF);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("post_rst_idle", {30'b0, busy, result_valid}, 32'd0);

        check("queues_drained", {15'b0, 8'(rq.size()), 9'(xq.size())}, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
